// File: rtl/seg7_hex_scan.sv
// Four-digit multiplexed hex display driver for two 8-bit register values.
// Shadows the values on a load strobe and scans common-anode digits at DIV clocks per slot.
module seg7_hex_scan #(
    parameter int unsigned DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] val_hi,
    input  logic [7:0] val_lo,
    input  logic       load,
    input  logic       blank,
    input  logic [3:0] dp_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [7:0]    r_shadow_hi;
    logic [7:0]    r_shadow_lo;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic [3:0]    w_nib;
    logic [6:0]    w_glyph;
    logic [3:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;

    // Prescaler and digit index; idx advances on the same edge the counter wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow_hi <= 8'h00;
            r_shadow_lo <= 8'h00;
        end else if (load) begin
            r_shadow_hi <= val_hi;
            r_shadow_lo <= val_lo;
        end
    end

    always_comb begin
        w_nib = 4'h0;
        case (r_idx)
            2'd0:    w_nib = r_shadow_lo[3:0];
            2'd1:    w_nib = r_shadow_lo[7:4];
            2'd2:    w_nib = r_shadow_hi[3:0];
            default: w_nib = r_shadow_hi[7:4];
        endcase
    end

    // Hex glyphs as {g,f,e,d,c,b,a}, active-low
    always_comb begin
        w_glyph = 7'b1111111;
        case (w_nib)
            4'h0:    w_glyph = 7'b1000000;
            4'h1:    w_glyph = 7'b1111001;
            4'h2:    w_glyph = 7'b0100100;
            4'h3:    w_glyph = 7'b0110000;
            4'h4:    w_glyph = 7'b0011001;
            4'h5:    w_glyph = 7'b0010010;
            4'h6:    w_glyph = 7'b0000010;
            4'h7:    w_glyph = 7'b1111000;
            4'h8:    w_glyph = 7'b0000000;
            4'h9:    w_glyph = 7'b0010000;
            4'hA:    w_glyph = 7'b0001000;
            4'hB:    w_glyph = 7'b0000011;
            4'hC:    w_glyph = 7'b1000110;
            4'hD:    w_glyph = 7'b0100001;
            4'hE:    w_glyph = 7'b0000110;
            default: w_glyph = 7'b0001110;
        endcase
    end

    // Blank turns every segment off too, so nothing glows while anodes are released
    always_comb begin
        w_an  = ~(4'b0001 << r_idx);
        w_seg = w_glyph;
        w_dp  = ~dp_mask[r_idx];
        if (blank) begin
            w_an  = 4'b1111;
            w_seg = 7'b1111111;
            w_dp  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_seg7_hex_scan.sv
// Self-checking bench for seg7_hex_scan: randomized stimulus against a cycle-count
// based display model (slot = edges/DIV mod 4, glyph looked up from a table).
module tb_seg7_hex_scan;

    localparam int unsigned DIV = 4;
    localparam logic [11:0] ALL_OFF = 12'hFFF;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] val_hi;
    logic [7:0] val_lo;
    logic       load;
    logic       blank;
    logic [3:0] dp_mask;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int errors = 0;
    int checks = 0;

    // Model state: edges counted since reset release and the captured values
    int          m_edges;
    logic [7:0]  m_hi;
    logic [7:0]  m_lo;
    logic [11:0] exp_out;
    logic [11:0] exp_mask;
    logic [6:0]  glyph [16];

    seg7_hex_scan #(.DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .val_hi  (val_hi),
        .val_lo  (val_lo),
        .load    (load),
        .blank   (blank),
        .dp_mask (dp_mask),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    function automatic int cur_slot();
        return (m_edges / int'(DIV)) % 4;
    endfunction

    // Expected {an,seg,dp} for the coming edge, derived from the pre-edge model and inputs
    function automatic void predict();
        int       s;
        logic [15:0] both;
        logic [3:0]  nib;
        s    = cur_slot();
        both = {m_hi, m_lo};
        nib  = 4'((both >> (4 * s)) & 16'h000F);
        if (blank) begin
            exp_out  = ALL_OFF;
            exp_mask = 12'b1111_0000000_1;
        end else begin
            exp_out  = {4'(~(1 << s)), glyph[nib], ~dp_mask[s]};
            exp_mask = 12'hFFF;
        end
    endfunction

    task automatic step();
        predict();
        @(posedge clk);
        m_edges++;
        if (load) begin
            m_hi = val_hi;
            m_lo = val_lo;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        m_edges = 0;
        m_hi = 8'h00;
        m_lo = 8'h00;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            val_hi = 8'($urandom); val_lo = 8'($urandom);
            load = 1'($urandom); blank = 1'($urandom); dp_mask = 4'($urandom);
            @(posedge clk); #1;
            obs = {an, seg, dp};
            checks++;
            if (obs !== ALL_OFF) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, ALL_OFF);
            end
        end
        load = 1'b0; blank = 1'b0; dp_mask = 4'b0000;
        m_edges = 0; m_hi = 8'h00; m_lo = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        obs = {an, seg, dp};
        checks++;
        if (obs !== 12'b1110_1000000_1) begin
            errors++;
            $display("FAIL reset_release_slot0: got %h expected %h", obs, 12'b1110_1000000_1);
        end
    endtask

    task automatic test_scan_order();
        logic [11:0] obs;
        do_reset();
        val_hi = 8'hA5; val_lo = 8'h3C; blank = 1'b0; dp_mask = 4'b0000;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            obs = {an, seg, dp};
            checks++;
            if ((obs & exp_mask) !== (exp_out & exp_mask)) begin
                errors++;
                $display("FAIL scan_order cycle %0d: got %h expected %h", i, obs, exp_out);
            end
        end
    endtask

    task automatic test_shadow_hold();
        logic [11:0] obs;
        val_hi = 8'hFF; val_lo = 8'hFF; load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            obs = {an, seg, dp};
            checks++;
            if ((obs & exp_mask) !== (exp_out & exp_mask)) begin
                errors++;
                $display("FAIL shadow_hold cycle %0d: got %h expected %h", i, obs, exp_out);
            end
        end
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        checks++;
        if (seg !== 7'b0001110) begin
            errors++;
            $display("FAIL shadow_reload_F: got %b expected %b", seg, 7'b0001110);
        end
    endtask

    task automatic test_all_glyphs();
        load = 1'b1; blank = 1'b0;
        for (int v = 0; v < 16; v++) begin
            val_hi = {4'(v), 4'(v)};
            val_lo = {4'(v), 4'(v)};
            step();
            step();
            checks++;
            if (seg !== glyph[v]) begin
                errors++;
                $display("FAIL glyph_%0h: got %b expected %b", v, seg, glyph[v]);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_blank_dp();
        logic [11:0] obs;
        val_hi = 8'($urandom); val_lo = 8'($urandom);
        load = 1'b1; step(); load = 1'b0;
        dp_mask = 4'b0101; blank = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            obs = {an, seg, dp};
            checks++;
            if ((obs & exp_mask) !== (exp_out & exp_mask)) begin
                errors++;
                $display("FAIL dp_mask cycle %0d: got %h expected %h", i, obs, exp_out);
            end
        end
        blank = 1'b1;
        step();
        checks++;
        if ({an, dp} !== 5'b1111_1) begin
            errors++;
            $display("FAIL blank_on: got an=%b dp=%b expected an=1111 dp=1", an, dp);
        end
        step();
        blank = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            obs = {an, seg, dp};
            checks++;
            if ((obs & exp_mask) !== (exp_out & exp_mask)) begin
                errors++;
                $display("FAIL unblank cycle %0d: got %h expected %h", i, obs, exp_out);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] obs;
        for (int i = 0; i < 300; i++) begin
            val_hi  = 8'($urandom);
            val_lo  = 8'($urandom);
            load    = ($urandom_range(0, 3) == 0);
            blank   = ($urandom_range(0, 7) == 0);
            dp_mask = 4'($urandom);
            step();
            obs = {an, seg, dp};
            checks++;
            if ((obs & exp_mask) !== (exp_out & exp_mask)) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp_out);
            end
        end
        load = 1'b0; blank = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [11:0] obs;
        val_hi = 8'h9E; val_lo = 8'h7B; dp_mask = 4'b0000; blank = 1'b0;
        load = 1'b1; step(); load = 1'b0;
        for (int i = 0; i < 16 && cur_slot() != 2; i++) step();
        step();
        #2;
        rst = 1'b0;
        #1;
        obs = {an, seg, dp};
        checks++;
        if (obs !== ALL_OFF) begin
            errors++;
            $display("FAIL async_reset_immediate: got %h expected %h", obs, ALL_OFF);
        end
        m_edges = 0; m_hi = 8'h00; m_lo = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        obs = {an, seg, dp};
        checks++;
        if (obs !== 12'b1110_1000000_1) begin
            errors++;
            $display("FAIL async_reset_restart: got %h expected %h", obs, 12'b1110_1000000_1);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            obs = {an, seg, dp};
            checks++;
            if ((obs & exp_mask) !== (exp_out & exp_mask)) begin
                errors++;
                $display("FAIL post_reset_scan cycle %0d: got %h expected %h", i, obs, exp_out);
            end
        end
    endtask

    initial begin
        glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        rst = 1'b0; val_hi = 8'h00; val_lo = 8'h00;
        load = 1'b0; blank = 1'b0; dp_mask = 4'b0000;
        m_edges = 0; m_hi = 8'h00; m_lo = 8'h00;
        exp_out = ALL_OFF; exp_mask = 12'hFFF;

        test_reset();
        test_scan_order();
        test_shadow_hold();
        test_all_glyphs();
        test_blank_dp();
        test_random();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
